// File: rtl/muldiv_seq.sv
// Iterative RV32M-style multiply/divide unit, one radix-2 step per clock; optional MULDIV_EARLY_OUT_EN.
// Latency: XLEN+1 cycles from accept to outValid, 1 cycle for divide-by-zero / signed overflow.
// Backpressure: inReady only in IDLE; result and outValid hold in DONE until outReady.
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            inValid,
    output logic            inReady,
    input  logic [XLEN-1:0] dataIn0,
    input  logic [XLEN-1:0] dataIn1,
    input  logic [2:0]      operation,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] dataOut,
    output logic            busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   dvsr;

    // Accept-time decode
    logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        is_div   = operation[2];
        a_sgn    = is_div ? ~operation[0] : (operation[1:0] != 2'b11);
        b_sgn    = is_div ? ~operation[0] : ~operation[1];
        a_neg    = a_sgn & dataIn0[XLEN-1];
        b_neg    = b_sgn & dataIn1[XLEN-1];
        a_mag    = a_neg ? -dataIn0 : dataIn0;
        b_mag    = b_neg ? -dataIn1 : dataIn1;
        div_zero = is_div && (dataIn1 == '0);
        div_ovf  = is_div && ~operation[0] && (dataIn0 == {1'b1, {(XLEN-1){1'b0}}})
                   && (dataIn1 == '1);
        fast     = div_zero | div_ovf;
        if (div_zero)
            fast_res = operation[1] ? dataIn0 : '1;
        else
            fast_res = operation[1] ? '0 : dataIn0;
    end

    // One iteration step for both datapaths
    logic [2*XLEN-1:0] prod_nxt, prod_fin;
    logic [XLEN:0]     r_sh, diff;
    logic              q_bit;
    logic [XLEN-1:0]   rem_nxt, quo_nxt, rem_fin, quo_fin;
    logic [XLEN-1:0]   res_fin;
    logic              last, early, finish;

    always_comb begin
        prod_nxt = mplier[0] ? (prod + mcand) : prod;
        r_sh     = {rem, quo[XLEN-1]};
        diff     = r_sh - {1'b0, dvsr};
        q_bit    = ~diff[XLEN];
        rem_nxt  = q_bit ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
        quo_nxt  = {quo[XLEN-2:0], q_bit};
        // neg_q already encodes the sign rule of the latched op (dividend sign for REM)
        prod_fin = neg_q ? -prod_nxt : prod_nxt;
        quo_fin  = neg_q ? -quo_nxt : quo_nxt;
        rem_fin  = neg_q ? -rem_nxt : rem_nxt;
        if (op_q[2])
            res_fin = op_q[1] ? rem_fin : quo_fin;
        else if (op_q[1:0] == 2'b00)
            res_fin = prod_fin[XLEN-1:0];
        else
            res_fin = prod_fin[2*XLEN-1:XLEN];
        last = (cnt == CNT_W'(XLEN - 1));
`ifdef MULDIV_EARLY_OUT_EN
        early = ~op_q[2] && (mplier[XLEN-1:1] == '0);
`else
        early = 1'b0;
`endif
        finish = last | early;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            prod    <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            dataOut <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (inValid) begin
                        cnt    <= '0;
                        op_q   <= operation;
                        neg_q  <= (is_div && operation[1]) ? a_neg : (a_neg ^ b_neg);
                        prod   <= '0;
                        mcand  <= {{XLEN{1'b0}}, a_mag};
                        mplier <= b_mag;
                        rem    <= '0;
                        quo    <= a_mag;
                        dvsr   <= b_mag;
                        if (fast) begin
                            dataOut <= fast_res;
                            state   <= S_DONE;
                        end else begin
                            state   <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    prod   <= prod_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    rem    <= rem_nxt;
                    quo    <= quo_nxt;
                    if (finish) begin
                        dataOut <= res_fin;
                        state   <= S_DONE;
                    end
                    if (!last)
                        cnt <= cnt + 1'b1;
                end
                S_DONE: begin
                    if (outReady)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign inReady  = (state == S_IDLE);
    assign outValid = (state == S_DONE);
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table, hand-written handshake/reset sequences, randomized ops vs a arithmetic reference model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rstN;
    logic        inValid;
    logic        inReady;
    logic [31:0] dataIn0;
    logic [31:0] dataIn1;
    logic [2:0]  operation;
    logic        outValid;
    logic        outReady;
    logic [31:0] dataOut;
    logic        busy;

    int checks = 0;
    int errors = 0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk(clk), .rstN(rstN),
        .inValid(inValid), .inReady(inReady),
        .dataIn0(dataIn0), .dataIn1(dataIn1), .operation(operation),
        .outValid(outValid), .outReady(outReady),
        .dataOut(dataOut), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, ub, q, r;
        logic [63:0] ua64, ub64, p;
        sa = $signed(a);
        sb = $signed(b);
        ub = {32'b0, b};
        ua64 = {32'b0, a};
        ub64 = {32'b0, b};
        p = '0;
        case (op)
            3'd0, 3'd1: p = sa * sb;
            3'd2:       p = sa * ub;
            3'd3:       p = ua64 * ub64;
            default:    p = '0;
        endcase
        if (!op[2])
            return (op == 3'd0) ? p[31:0] : p[63:32];
        if (b == 32'd0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return op[1] ? 32'd0 : a;
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = longint'(ua64 / ub64);
            r = longint'(ua64 % ub64);
        end
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    // Edges from the accept edge (counted as 1) until outValid is seen
    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag;
        int          nbits;
        if (op[2] && (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[2]) begin
            mag = (op[1] == 1'b0 && b[31]) ? -b : b;
            nbits = 1;
            for (int i = 0; i < 32; i++)
                if (mag[i]) nbits = i + 1;
            return 1 + nbits;
        end
`else
        mag = a ^ b;
        nbits = (mag == 32'd0) ? 0 : 0;
`endif
        return 33 + nbits;
    endfunction

    task automatic scramble();
        dataIn0   = $urandom;
        dataIn1   = $urandom;
        operation = 3'($urandom);
    endtask

    // Called at #1 after a posedge with the unit idle; returns #1 after the accept edge
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        operation = op;
        dataIn0   = a;
        dataIn1   = b;
        inValid   = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        scramble();
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!outValid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("done_timeout", {31'b0, outValid}, 32'd1);
    endtask

    task automatic release_res();
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat;
        start_op(op, a, b);
        wait_done(lat);
        chk({name, "_res"}, dataOut, exp);
        chk({name, "_lat"}, lat, exp_lat(op, a, b));
        release_res();
        chk({name, "_idle"}, {31'b0, inReady}, 32'd1);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          lat;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        tbl[0]  = '{"mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        tbl[1]  = '{"mul_small",  3'd0, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340};
        tbl[2]  = '{"mulhsu_m1",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[3]  = '{"mulhu_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[4]  = '{"mul_neg",    3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1};
        tbl[5]  = '{"div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        tbl[6]  = '{"rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        tbl[7]  = '{"div_7_m2",   3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
        tbl[8]  = '{"rem_7_m2",   3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1};
        tbl[9]  = '{"divu_100_7", 3'd5, 32'd100,       32'd7,         32'd14};
        tbl[10] = '{"remu_100_7", 3'd7, 32'd100,       32'd7,         32'd2};
        tbl[11] = '{"divu_5_0",   3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF};
        tbl[12] = '{"remu_5_0",   3'd7, 32'd5,         32'd0,         32'd5};
        tbl[13] = '{"div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};

        rstN = 1'b0;
        inValid = 1'b0;
        outReady = 1'b0;
        dataIn0 = '0;
        dataIn1 = '0;
        operation = '0;
        #12;
        chk("rst_inready", {31'b0, inReady}, 32'd1);
        chk("rst_outvalid", {31'b0, outValid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_dataout", dataOut, 32'd0);
        #10 rstN = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++)
            run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Backpressure: result holds while outReady stays low
        start_op(3'd1, 32'h8000_0000, 32'h8000_0000);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_data", dataOut, 32'h4000_0000);
            chk("bp_valid", {31'b0, outValid}, 32'd1);
            chk("bp_inready", {31'b0, inReady}, 32'd0);
        end
        // inValid on the releasing edge must not be taken
        operation = 3'd5;
        dataIn0 = 32'd100;
        dataIn1 = 32'd7;
        inValid = 1'b1;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        chk("sim_outvalid", {31'b0, outValid}, 32'd0);
        chk("sim_busy", {31'b0, busy}, 32'd0);
        chk("sim_inready", {31'b0, inReady}, 32'd1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        chk("sim_accept", {31'b0, busy}, 32'd1);
        scramble();
        wait_done(lat);
        chk("sim_res", dataOut, 32'd14);
        release_res();

        // Operand churn during BUSY
        start_op(3'd0, 32'h0000_1234, 32'h0000_0010);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            scramble();
        end
        wait_done(lat);
        chk("churn_res", dataOut, 32'h0001_2340);
        release_res();

        // Reset in the middle of an operation
        start_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        chk("mid_rst_outvalid", {31'b0, outValid}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_inready", {31'b0, inReady}, 32'd1);
        chk("mid_rst_dataout", dataOut, 32'd0);
        #1 rstN = 1'b1;
        @(posedge clk);
        #1;
        run_op("post_rst", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);

`ifdef MULDIV_EARLY_OUT_EN
        start_op(3'd0, 32'd7, 32'd1);
        wait_done(lat);
        chk("eo_mul_res", dataOut, 32'd7);
        chk("eo_mul_fast", {31'b0, (lat <= 2)}, 32'd1);
        release_res();
        run_op("eo_mulhu_full", 3'd3, 32'd7, 32'h8000_0000, 32'd3);
`endif

        for (int n = 0; n < 150; n++) begin
            rop = 3'($urandom);
            ra  = pick();
            rb  = pick();
            run_op($sformatf("rnd%0d_op%0d", n, rop), rop, ra, rb, ref_res(rop, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
